gpr_wb_arb: RTL and testbench

Write-back arbiter and scoreboard in front of the general-purpose register file's single write port. It merges single-cycle pipeline write-backs (including the jal link write) with results from long-latency units such as load/multiply. Long-latency results are buffered in a small FIFO and drained into free write slots. A per-register pending vector lets decode stall on registers whose long-latency result has not yet been written.

---
 rtl/gpr_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 57 +++++
 rtl/gpr_wb_arb.sv | 132 +++++++++++++
 tb/tb_gpr_wb_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR write-back path.
package gpr_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_LINK = 5'd30;

  // One buffered long-latency result: destination register and value.
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Destination of a pipeline write-back; jal always links into r30.
  function automatic logic [REG_W-1:0] pw_target(input logic             link,
                                                 input logic [REG_W-1:0] addr);
    return link ? REG_LINK : addr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small count-based FIFO holding long-latency write-back entries.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; a cleared count makes stale contents unreachable.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpr_wb_arb.sv
// Write-back arbiter for the GPR write port: pipeline results win the slot,
// buffered long-latency results drain into free slots, and a pending vector
// tells decode which registers still await a long-latency write.
module gpr_wb_arb
  import gpr_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pw_en,
  input  logic              pw_link,
  input  logic [REG_W-1:0]  pw_addr,
  input  logic [DATA_W-1:0] pw_data,
  input  logic              lw_valid,
  output logic              lw_ready,
  input  logic [REG_W-1:0]  lw_addr,
  input  logic [DATA_W-1:0] lw_data,
  input  logic              sb_set,
  input  logic [REG_W-1:0]  sb_addr,
  input  logic [REG_W-1:0]  qa,
  input  logic [REG_W-1:0]  qb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall_req,
  output logic              RegWrite,
  output logic [REG_W-1:0]  rw,
  output logic [DATA_W-1:0] wd
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  wb_entry_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              slot_valid;
  logic [REG_W-1:0]  slot_addr;
  logic [DATA_W-1:0] slot_data;

  logic [31:0]       pending;
  logic [31:0]       pending_next;
  logic [CNT_W-1:0]  starve_cnt;

  // Ready is purely the full flag, so there is no combinational path from pop to ready.
  assign lw_ready = !fifo_full;
  assign push     = lw_valid && !fifo_full;
  assign pop      = !pw_en && !fifo_empty;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data('{addr: lw_addr, data: lw_data}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Slot mux: pipeline write first, otherwise the FIFO head; r0 targets never write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    slot_valid = 1'b0;
    slot_addr  = fifo_head.addr;
    slot_data  = fifo_head.data;
    if (pw_en) begin
      slot_addr  = pw_target(pw_link, pw_addr);
      slot_data  = pw_data;
      slot_valid = (slot_addr != REG_ZERO);
    end else if (pop) begin
      slot_valid = (fifo_head.addr != REG_ZERO);
    end
  end

  // Registered write-port outputs; address and data hold when no write is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite <= 1'b0;
      rw       <= '0;
      wd       <= '0;
    end else begin
      RegWrite <= slot_valid;
      if (slot_valid) begin
        rw <= slot_addr;
        wd <= slot_data;
      end
    end
  end

  // Pending update: a drain clears its bit, a new issue sets one, set wins, r0 never set.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[fifo_head.addr] = 1'b0;
    if (sb_set && (sb_addr != REG_ZERO))
      pending_next[sb_addr] = 1'b1;
  end

  // Pending vector register; clears on the same edge that loads the drained write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  assign busy_a = pending[qa];
  assign busy_b = pending[qb];

  // Starvation counter: counts slots the pipeline takes while results wait, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (pw_en && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Bubble request, registered one cycle behind the saturated counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_req <= 1'b0;
    else      stall_req <= (starve_cnt == STARVE_LIM);
  end

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Self-checking bench for gpr_wb_arb against a queue-based reference model.
module tb_gpr_wb_arb;
  import gpr_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pw_en = 1'b0, pw_link = 1'b0;
  logic [4:0]  pw_addr = '0;
  logic [31:0] pw_data = '0;
  logic        lw_valid = 1'b0;
  logic        lw_ready;
  logic [4:0]  lw_addr = '0;
  logic [31:0] lw_data = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0, qa = '0, qb = '0;
  logic        busy_a, busy_b, stall_req, RegWrite;
  logic [4:0]  rw;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;

  // Reference model state
  wb_entry_t   q[$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        exp_we, exp_stall;
  logic [4:0]  exp_rw;
  logic [31:0] exp_wd;

  gpr_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pw_en(pw_en), .pw_link(pw_link), .pw_addr(pw_addr), .pw_data(pw_data),
    .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_addr(lw_addr), .lw_data(lw_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b), .stall_req(stall_req),
    .RegWrite(RegWrite), .rw(rw), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_pend    = '0;
    m_starve  = 0;
    exp_we    = 1'b0;
    exp_stall = 1'b0;
    exp_rw    = '0;
    exp_wd    = '0;
  endtask

  task automatic idle_inputs();
    pw_en = 0; pw_link = 0; pw_addr = '0; pw_data = '0;
    lw_valid = 0; lw_addr = '0; lw_data = '0;
    sb_set = 0; sb_addr = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit          push_ok, pop_ok;
    logic [4:0]  tgt;
    wb_entry_t   hd;
    #1;
    checks++;
    if (lw_ready !== (q.size() < DEPTH)) begin
      errors++; $display("FAIL lw_ready got %b exp %b", lw_ready, q.size() < DEPTH);
    end
    checks++;
    if (busy_a !== m_pend[qa]) begin
      errors++; $display("FAIL busy_a r%0d got %b exp %b", qa, busy_a, m_pend[qa]);
    end
    checks++;
    if (busy_b !== m_pend[qb]) begin
      errors++; $display("FAIL busy_b r%0d got %b exp %b", qb, busy_b, m_pend[qb]);
    end

    push_ok = lw_valid && (q.size() < DEPTH);
    pop_ok  = !pw_en && (q.size() > 0);
    hd      = (q.size() > 0) ? q[0] : '0;
    exp_stall = (m_starve == STARVE_MAX);
    exp_we  = 1'b0;
    if (pw_en) begin
      tgt = pw_link ? 5'd30 : pw_addr;
      if (tgt != 0) begin exp_we = 1'b1; exp_rw = tgt; exp_wd = pw_data; end
    end else if (pop_ok && hd.addr != 0) begin
      exp_we = 1'b1; exp_rw = hd.addr; exp_wd = hd.data;
    end
    if (pop_ok) m_pend[hd.addr] = 1'b0;
    if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
    if (q.size() == 0 || pop_ok) m_starve = 0;
    else if (pw_en && m_starve < STARVE_MAX) m_starve++;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back('{addr: lw_addr, data: lw_data});

    @(posedge clk);
    #1;
    checks++;
    if (RegWrite !== exp_we) begin
      errors++; $display("FAIL RegWrite got %b exp %b", RegWrite, exp_we);
    end
    checks++;
    if (rw !== exp_rw) begin
      errors++; $display("FAIL rw got %0d exp %0d", rw, exp_rw);
    end
    checks++;
    if (wd !== exp_wd) begin
      errors++; $display("FAIL wd got %h exp %h", wd, exp_wd);
    end
    checks++;
    if (stall_req !== exp_stall) begin
      errors++; $display("FAIL stall_req got %b exp %b", stall_req, exp_stall);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #12;
    checks++;
    if ({RegWrite, rw, wd, stall_req, lw_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got we=%b rw=%0d wd=%h stall=%b ready=%b exp 0 0 0 0 1",
               RegWrite, rw, wd, stall_req, lw_ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_link();
    idle_inputs();
    pw_en = 1; pw_link = 1; pw_addr = 5'd7; pw_data = 32'h1234;
    step();
    checks++;
    if (RegWrite !== 1'b1 || rw !== 5'd30 || wd !== 32'h1234) begin
      errors++; $display("FAIL link_write got we=%b rw=%0d wd=%h exp 1 30 00001234", RegWrite, rw, wd);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_drain_busy();
    idle_inputs();
    qa = 5'd5; qb = 5'd6;
    sb_set = 1; sb_addr = 5'd5;
    step();
    idle_inputs();
    lw_valid = 1; lw_addr = 5'd5; lw_data = 32'hDEADBEEF;
    step();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL busy_r5_before got %b exp 1", busy_a);
    end
    idle_inputs();
    step();
    checks++;
    if (RegWrite !== 1'b1 || rw !== 5'd5 || wd !== 32'hDEADBEEF || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL drain_r5 got we=%b rw=%0d wd=%h busy=%b exp 1 5 deadbeef 0", RegWrite, rw, wd, busy_a);
    end
    step();
  endtask

  task automatic test_starve();
    bit seen_stall = 0, seen_full = 0;
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      pw_en = 1; pw_addr = 5'd3; pw_data = 32'hA000_0000 + i;
      lw_valid = 1; lw_addr = 5'(10 + i); lw_data = 32'hB000_0000 + i;
      step();
      if (lw_ready === 1'b0) seen_full = 1;
      if (stall_req === 1'b1) seen_stall = 1;
    end
    checks++;
    if (!seen_full || !seen_stall) begin
      errors++; $display("FAIL starve_phase got full=%b stall=%b exp 1 1", seen_full, seen_stall);
    end
    pw_en = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) lw_valid = 0;
      step();
    end
    checks++;
    if (stall_req !== 1'b0 || lw_ready !== 1'b1) begin
      errors++; $display("FAIL starve_drained got stall=%b ready=%b exp 0 1", stall_req, lw_ready);
    end
  endtask

  task automatic test_set_wins();
    idle_inputs();
    qa = 5'd9;
    sb_set = 1; sb_addr = 5'd9;
    step();
    idle_inputs();
    pw_en = 1; pw_addr = 5'd2; pw_data = 32'h55;
    lw_valid = 1; lw_addr = 5'd9; lw_data = 32'h99;
    step();
    idle_inputs();
    sb_set = 1; sb_addr = 5'd9;
    step();
    idle_inputs();
    step();
    checks++;
    if (busy_a !== 1'b1 || rw !== 5'd9) begin
      errors++; $display("FAIL set_wins got busy=%b rw=%0d exp 1 9", busy_a, rw);
    end
  endtask

  task automatic test_r0();
    bit seen_we = 0;
    idle_inputs();
    qa = 5'd0;
    pw_en = 1; pw_addr = 5'd0; pw_data = 32'hFFFF_0000;
    lw_valid = 1; lw_addr = 5'd0; lw_data = 32'h0000_FFFF;
    sb_set = 1; sb_addr = 5'd0;
    step();
    if (RegWrite) seen_we = 1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      if (RegWrite) seen_we = 1;
    end
    checks++;
    if (seen_we || busy_a !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL r0_write got we_seen=%b busy0=%b exp 0 0", seen_we, busy_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pw_en    = ($urandom_range(0, 99) < 45);
      pw_link  = ($urandom_range(0, 7) == 0);
      pw_addr  = 5'($urandom_range(0, 7));
      pw_data  = $urandom;
      lw_valid = ($urandom_range(0, 99) < 50);
      lw_addr  = 5'($urandom_range(0, 7));
      lw_data  = $urandom;
      sb_set   = ($urandom_range(0, 3) == 0);
      sb_addr  = 5'($urandom_range(0, 7));
      qa       = 5'($urandom_range(0, 7));
      qb       = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      pw_en = 1; pw_addr = 5'd1; pw_data = i;
      lw_valid = 1; lw_addr = 5'(20 + i); lw_data = 32'hC0 + i;
      sb_set = 1; sb_addr = 5'(20 + i);
      step();
    end
    idle_inputs();
    qa = 5'd21; qb = 5'd22;
    step();
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({RegWrite, stall_req, lw_ready, busy_a, busy_b} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid got we=%b stall=%b ready=%b busy=%b%b exp 0 0 1 00",
               RegWrite, stall_req, lw_ready, busy_a, busy_b);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    test_reset();
    test_link();
    test_drain_busy();
    test_starve();
    test_set_wins();
    test_r0();
    test_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
